hk_config_loader: RTL and testbench

Parametrised housekeeping loader. After reset it streams configuration words from the SPI flash shift register and writes each one over a Wishbone master into a NUM_SOCLETS x ROWS_PER_SOCLET grid of node registers. It adds three things to the fixed 9x10 loader: optional write-readback verify, an ack timeout with bounded retry, and error/progress reporting. It sits between the flash shift register and the Wishbone interconnect, and gates SRAM handoff through done_loading.

---
 rtl/hk_loader_pkg.sv | 28 ++
 rtl/hk_addr_gen.sv | 50 +++++
 rtl/hk_config_loader.sv | 184 ++++++++++++++++++
 tb/tb_hk_config_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hk_loader_pkg.sv
// Shared types and helpers for the housekeeping configuration loader.
package hk_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WB_WRITE,
    WB_READ,
    RETRY,
    NEXT,
    GAP,
    DONE,
    FAIL
  } hk_state_e;

  localparam int ERR_W = 8;

  function automatic logic [31:0] hk_addr(
    input logic [31:0] base,
    input logic [31:0] s,
    input logic [31:0] r,
    input logic [31:0] soclet_stride,
    input logic [31:0] row_stride
  );
    return base + s * soclet_stride + r * row_stride;
  endfunction

endpackage

// File: rtl/hk_addr_gen.sv
// Soclet/row walker: holds the current grid position and its registered
// Wishbone address, stepping row-major on advance.
module hk_addr_gen
  import hk_loader_pkg::*;
#(
  parameter int          NUM_SOCLETS     = 9,
  parameter int          ROWS_PER_SOCLET = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h1000,
  parameter int          SOCLET_STRIDE   = 64,
  parameter int          ROW_STRIDE      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        advance,
  output logic        last_row,
  output logic        last_soclet,
  output logic [31:0] adr
);

  localparam int SW = (NUM_SOCLETS > 1) ? $clog2(NUM_SOCLETS) : 1;
  localparam int RW = (ROWS_PER_SOCLET > 1) ? $clog2(ROWS_PER_SOCLET) : 1;

  logic [SW-1:0] soclet;
  logic [RW-1:0] row;

  assign last_row    = (row == RW'(ROWS_PER_SOCLET - 1));
  assign last_soclet = (soclet == SW'(NUM_SOCLETS - 1));

  // The address is computed one step ahead so it is stable before stb rises.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      soclet <= '0;
      row    <= '0;
      adr    <= BASE_ADDR;
    end else if (advance) begin
      if (!last_row) begin
        row <= row + RW'(1);
        adr <= hk_addr(BASE_ADDR, 32'(soclet), 32'(row) + 32'd1,
                       32'(SOCLET_STRIDE), 32'(ROW_STRIDE));
      end else if (!last_soclet) begin
        row    <= '0;
        soclet <= soclet + SW'(1);
        adr    <= hk_addr(BASE_ADDR, 32'(soclet) + 32'd1, 32'd0,
                          32'(SOCLET_STRIDE), 32'(ROW_STRIDE));
      end
    end
  end

endmodule

// File: rtl/hk_config_loader.sv
// Streams flash config words into the node register grid over Wishbone,
// with optional readback verify, ack timeout, bounded retry and error reporting.
module hk_config_loader
  import hk_loader_pkg::*;
#(
  parameter int          DATA_W          = 32,
  parameter int          NUM_SOCLETS     = 9,
  parameter int          ROWS_PER_SOCLET = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h1000,
  parameter int          SOCLET_STRIDE   = 64,
  parameter int          ROW_STRIDE      = 4,
  parameter int          ACK_TIMEOUT     = 255,
  parameter int          MAX_RETRY       = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bypass_en,
  input  logic                verify_en,
  input  logic                word_ready,
  input  logic [DATA_W-1:0]   shifted_word,
  output logic                fetch_en,
  output logic                fetch_o,
  output logic                flash_csb,
  output logic [31:0]         wbs_adr,
  output logic [DATA_W-1:0]   wbs_dat_o,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  output logic                wbs_cyc,
  output logic                wbs_stb,
  output logic                wbs_we,
  output logic [DATA_W/8-1:0] wbs_sel,
  input  logic                wbs_ack,
  input  logic                wbs_err,
  output logic                done_loading,
  output logic                load_error,
  output logic [ERR_W-1:0]    err_count,
  output logic [15:0]         words_loaded,
  output hk_state_e           dbg_state
);

  // Wishbone handshake: a transfer is outstanding while cyc and stb are high;
  // it completes on the first cycle the slave raises ack or err (err wins).
  localparam int TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  hk_state_e        state;
  logic             verify_q;
  logic [DATA_W-1:0] word_q;
  logic [TW-1:0]    tmo;
  logic [RTW-1:0]   retry;
  logic             last_row;
  logic             last_soclet;
  logic             tmo_hit;
  logic             bus_fail;
  logic             rd_mismatch;

  hk_addr_gen #(
    .NUM_SOCLETS    (NUM_SOCLETS),
    .ROWS_PER_SOCLET(ROWS_PER_SOCLET),
    .BASE_ADDR      (BASE_ADDR),
    .SOCLET_STRIDE  (SOCLET_STRIDE),
    .ROW_STRIDE     (ROW_STRIDE)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (bypass_en),
    .advance    (state == NEXT),
    .last_row   (last_row),
    .last_soclet(last_soclet),
    .adr        (wbs_adr)
  );

  assign fetch_o     = (state == FETCH);
  assign wbs_sel     = '1;
  assign dbg_state   = state;
  assign tmo_hit     = (tmo == TW'(ACK_TIMEOUT - 1));
  assign bus_fail    = wbs_err || (!wbs_ack && tmo_hit);
  assign rd_mismatch = wbs_ack && !wbs_err && !wbs_we && (wbs_dat_i != word_q);

  always_ff @(posedge clk) begin
    if (reset || bypass_en) begin
      state        <= IDLE;
      verify_q     <= 1'b0;
      word_q       <= '0;
      tmo          <= '0;
      retry        <= '0;
      flash_csb    <= 1'b1;
      fetch_en     <= 1'b0;
      wbs_cyc      <= 1'b0;
      wbs_stb      <= 1'b0;
      wbs_we       <= 1'b0;
      wbs_dat_o    <= '0;
      done_loading <= 1'b0;
      load_error   <= 1'b0;
      err_count    <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE: begin
          flash_csb <= 1'b0;
          verify_q  <= verify_en;
          fetch_en  <= 1'b1;
          state     <= FETCH;
        end
        FETCH: begin
          if (word_ready) begin
            word_q    <= shifted_word;
            wbs_dat_o <= shifted_word;
            wbs_cyc   <= 1'b1;
            wbs_stb   <= 1'b1;
            wbs_we    <= 1'b1;
            fetch_en  <= 1'b0;
            tmo       <= '0;
            state     <= WB_WRITE;
          end
        end
        WB_WRITE, WB_READ: begin
          // WB_READ is entered with stb low after the write completes.
          if (!wbs_stb) begin
            wbs_cyc <= 1'b1;
            wbs_stb <= 1'b1;
            tmo     <= '0;
          end else if (bus_fail || rd_mismatch) begin
            if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
            wbs_stb <= 1'b0;
            wbs_we  <= 1'b0;
            if (retry == RTW'(MAX_RETRY)) begin
              wbs_cyc    <= 1'b0;
              flash_csb  <= 1'b1;
              load_error <= 1'b1;
              state      <= FAIL;
            end else begin
              retry <= retry + RTW'(1);
              state <= RETRY;
            end
          end else if (wbs_ack) begin
            wbs_cyc <= 1'b0;
            wbs_stb <= 1'b0;
            wbs_we  <= 1'b0;
            state   <= (state == WB_WRITE && verify_q) ? WB_READ : NEXT;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        RETRY: begin
          wbs_cyc <= 1'b1;
          wbs_stb <= 1'b1;
          wbs_we  <= 1'b1;
          tmo     <= '0;
          state   <= WB_WRITE;
        end
        NEXT: begin
          words_loaded <= words_loaded + 16'd1;
          retry        <= '0;
          if (!last_row) begin
            fetch_en <= 1'b1;
            state    <= FETCH;
          end else if (!last_soclet) begin
            state <= GAP;
          end else begin
            flash_csb    <= 1'b1;
            done_loading <= 1'b1;
            state        <= DONE;
          end
        end
        GAP: begin
          fetch_en <= 1'b1;
          state    <= FETCH;
        end
        DONE: begin
          flash_csb    <= 1'b1;
          done_loading <= 1'b1;
        end
        FAIL: begin
          flash_csb  <= 1'b1;
          load_error <= 1'b1;
          wbs_cyc    <= 1'b0;
          wbs_stb    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hk_config_loader.sv
// Directed bench for hk_config_loader on a 2x3 grid with an 8-cycle ack timeout.
module tb_hk_config_loader;
  import hk_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bypass_en = 1'b0;
  logic        verify_en = 1'b0;
  logic        word_ready = 1'b0;
  logic [31:0] shifted_word = '0;
  logic        fetch_en, fetch_o, flash_csb;
  logic [31:0] wbs_adr, wbs_dat_o;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]  wbs_sel;
  logic        wbs_ack = 1'b0;
  logic        wbs_err = 1'b0;
  logic        done_loading, load_error;
  logic [7:0]  err_count;
  logic [15:0] words_loaded;
  hk_state_e   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Slave behaviour knobs, written only by the test sequence.
  logic        err_first_en = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_adr = '0;
  logic        noack_en = 1'b0;
  logic [31:0] noack_adr = '0;

  // Bus log and monitors, written only by the model blocks.
  logic [31:0] log_adr[$];
  logic        log_we[$];
  logic [31:0] log_dat[$];
  int          att_len[$];
  int          gap_cycles = 0;
  int          gap_at = -1;
  logic        stb_prev = 1'b0;
  int          word_idx = 0;
  logic        err_used = 1'b0;
  logic        corrupt_used = 1'b0;
  logic [31:0] mem [logic [31:0]];

  hk_config_loader #(
    .DATA_W(32), .NUM_SOCLETS(2), .ROWS_PER_SOCLET(3), .BASE_ADDR(32'h1000),
    .SOCLET_STRIDE(64), .ROW_STRIDE(4), .ACK_TIMEOUT(8), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .bypass_en(bypass_en), .verify_en(verify_en),
    .word_ready(word_ready), .shifted_word(shifted_word), .fetch_en(fetch_en),
    .fetch_o(fetch_o), .flash_csb(flash_csb), .wbs_adr(wbs_adr),
    .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i), .wbs_cyc(wbs_cyc),
    .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_sel(wbs_sel), .wbs_ack(wbs_ack),
    .wbs_err(wbs_err), .done_loading(done_loading), .load_error(load_error),
    .err_count(err_count), .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // Flash shift register model: words 0xA0, 0xA1, ... in order.
  always @(negedge clk) begin
    if (reset || bypass_en) begin
      word_idx = 0;
      word_ready = 1'b0;
    end else if (word_ready && !fetch_en) begin
      word_ready = 1'b0;
      word_idx++;
    end else if (!word_ready && fetch_en) begin
      word_ready = 1'b1;
      shifted_word = 32'hA0 + 32'(word_idx);
    end
  end

  // Wishbone slave model with zero wait states and fault injection.
  always @(negedge clk) begin
    if (reset || bypass_en) begin
      wbs_ack = 1'b0;
      wbs_err = 1'b0;
      err_used = 1'b0;
      corrupt_used = 1'b0;
      log_adr.delete();
      log_we.delete();
      log_dat.delete();
    end else if (wbs_ack || wbs_err) begin
      wbs_ack = 1'b0;
      wbs_err = 1'b0;
    end else if (wbs_cyc && wbs_stb && !(noack_en && wbs_adr == noack_adr)) begin
      if (wbs_we && err_first_en && !err_used) begin
        err_used = 1'b1;
        wbs_err = 1'b1;
      end else begin
        wbs_ack = 1'b1;
        if (wbs_we) mem[wbs_adr] = wbs_dat_o;
        else begin
          wbs_dat_i = mem.exists(wbs_adr) ? mem[wbs_adr] : 32'h0;
          if (corrupt_en && !corrupt_used && wbs_adr == corrupt_adr) begin
            corrupt_used = 1'b1;
            wbs_dat_i = ~wbs_dat_i;
          end
        end
      end
      log_adr.push_back(wbs_adr);
      log_we.push_back(wbs_we);
      log_dat.push_back(wbs_we ? wbs_dat_o : wbs_dat_i);
    end
  end

  // Strobe-length and GAP monitor.
  always @(negedge clk) begin
    if (reset || bypass_en) begin
      att_len.delete();
      gap_cycles = 0;
      gap_at = -1;
      stb_prev = 1'b0;
    end else begin
      if (dbg_state == GAP) begin
        gap_cycles++;
        gap_at = log_adr.size();
      end
      if (wbs_stb) begin
        if (!stb_prev) att_len.push_back(1);
        else att_len[att_len.size()-1] = att_len[att_len.size()-1] + 1;
      end
      stb_prev = wbs_stb;
    end
  end

  // Driver tasks
  task automatic do_reset();
    reset = 1'b1;
    bypass_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_load(output bit finished);
    finished = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (done_loading || load_error) begin
        finished = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (flash_csb !== 1'b1) begin tests_failed++; $display("FAIL rst_csb: got %0b expected 1", flash_csb); end
    tests_run++; if (fetch_en !== 1'b0) begin tests_failed++; $display("FAIL rst_fetch_en: got %0b expected 0", fetch_en); end
    tests_run++; if (fetch_o !== 1'b0) begin tests_failed++; $display("FAIL rst_fetch_o: got %0b expected 0", fetch_o); end
    tests_run++; if ({wbs_cyc, wbs_stb, wbs_we} !== 3'b000) begin tests_failed++; $display("FAIL rst_bus_ctl: got %03b expected 000", {wbs_cyc, wbs_stb, wbs_we}); end
    tests_run++; if (wbs_adr !== 32'h1000) begin tests_failed++; $display("FAIL rst_adr: got %h expected 00001000", wbs_adr); end
    tests_run++; if (wbs_dat_o !== 32'h0) begin tests_failed++; $display("FAIL rst_dat: got %h expected 0", wbs_dat_o); end
    tests_run++; if (wbs_sel !== 4'hF) begin tests_failed++; $display("FAIL rst_sel: got %h expected f", wbs_sel); end
    tests_run++; if ({done_loading, load_error} !== 2'b00) begin tests_failed++; $display("FAIL rst_flags: got %02b expected 00", {done_loading, load_error}); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL rst_err_count: got %0d expected 0", err_count); end
    tests_run++; if (words_loaded !== 16'd0) begin tests_failed++; $display("FAIL rst_words: got %0d expected 0", words_loaded); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_basic_load();
    logic [31:0] exp_adr [6] = '{32'h1000, 32'h1004, 32'h1008, 32'h1040, 32'h1044, 32'h1048};
    bit fin;
    verify_en = 1'b0;
    do_reset();
    run_load(fin);
    tests_run++; if (fin !== 1'b1) begin tests_failed++; $display("FAIL basic_finished: got %0b expected 1", fin); end
    tests_run++; if (log_adr.size() != 6) begin tests_failed++; $display("FAIL basic_txn_count: got %0d expected 6", log_adr.size()); end
    for (int i = 0; i < 6 && i < log_adr.size(); i++) begin
      tests_run++;
      if ({log_we[i], log_adr[i], log_dat[i]} !== {1'b1, exp_adr[i], 32'hA0 + 32'(i)}) begin
        tests_failed++;
        $display("FAIL basic_txn%0d: got we=%0b adr=%h dat=%h expected we=1 adr=%h dat=%h",
                 i, log_we[i], log_adr[i], log_dat[i], exp_adr[i], 32'hA0 + 32'(i));
      end
    end
    tests_run++; if (gap_cycles != 1) begin tests_failed++; $display("FAIL basic_gap_cycles: got %0d expected 1", gap_cycles); end
    tests_run++; if (gap_at != 3) begin tests_failed++; $display("FAIL basic_gap_position: got %0d expected 3", gap_at); end
    tests_run++; if (done_loading !== 1'b1) begin tests_failed++; $display("FAIL basic_done: got %0b expected 1", done_loading); end
    tests_run++; if (words_loaded !== 16'd6) begin tests_failed++; $display("FAIL basic_words: got %0d expected 6", words_loaded); end
    tests_run++; if (flash_csb !== 1'b1) begin tests_failed++; $display("FAIL basic_csb: got %0b expected 1", flash_csb); end
    tests_run++; if ({load_error, err_count} !== 9'd0) begin tests_failed++; $display("FAIL basic_errors: got le=%0b ec=%0d expected 0 0", load_error, err_count); end
  endtask

  task automatic test_verify();
    logic [31:0] exp_adr [6] = '{32'h1000, 32'h1004, 32'h1008, 32'h1040, 32'h1044, 32'h1048};
    bit fin;
    verify_en = 1'b1;
    do_reset();
    run_load(fin);
    tests_run++; if (fin !== 1'b1) begin tests_failed++; $display("FAIL verify_finished: got %0b expected 1", fin); end
    tests_run++; if (log_adr.size() != 12) begin tests_failed++; $display("FAIL verify_txn_count: got %0d expected 12", log_adr.size()); end
    for (int i = 0; i < 12 && i < log_adr.size(); i++) begin
      tests_run++;
      if ({log_we[i], log_adr[i], log_dat[i]} !== {(i % 2) == 0, exp_adr[i/2], 32'hA0 + 32'(i/2)}) begin
        tests_failed++;
        $display("FAIL verify_txn%0d: got we=%0b adr=%h dat=%h expected we=%0b adr=%h dat=%h",
                 i, log_we[i], log_adr[i], log_dat[i], (i % 2) == 0, exp_adr[i/2], 32'hA0 + 32'(i/2));
      end
    end
    tests_run++; if (done_loading !== 1'b1) begin tests_failed++; $display("FAIL verify_done: got %0b expected 1", done_loading); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL verify_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_verify_corrupt();
    logic [31:0] exp_adr [6] = '{32'h1000, 32'h1004, 32'h1008, 32'h1040, 32'h1044, 32'h1048};
    int wi [14] = '{0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
    bit fin;
    verify_en = 1'b1;
    corrupt_en = 1'b1;
    corrupt_adr = 32'h1004;
    do_reset();
    run_load(fin);
    corrupt_en = 1'b0;
    tests_run++; if (fin !== 1'b1) begin tests_failed++; $display("FAIL corrupt_finished: got %0b expected 1", fin); end
    tests_run++; if (log_adr.size() != 14) begin tests_failed++; $display("FAIL corrupt_txn_count: got %0d expected 14", log_adr.size()); end
    for (int i = 0; i < 14 && i < log_adr.size(); i++) begin
      tests_run++;
      if ({log_we[i], log_adr[i]} !== {(i % 2) == 0, exp_adr[wi[i]]}) begin
        tests_failed++;
        $display("FAIL corrupt_txn%0d: got we=%0b adr=%h expected we=%0b adr=%h",
                 i, log_we[i], log_adr[i], (i % 2) == 0, exp_adr[wi[i]]);
      end
    end
    if (log_adr.size() >= 6) begin
      tests_run++; if (log_dat[4] !== 32'hA1) begin tests_failed++; $display("FAIL corrupt_rewrite_dat: got %h expected 000000a1", log_dat[4]); end
      tests_run++; if (log_dat[5] !== 32'hA1) begin tests_failed++; $display("FAIL corrupt_reread_dat: got %h expected 000000a1", log_dat[5]); end
    end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL corrupt_err_count: got %0d expected 1", err_count); end
    tests_run++; if (done_loading !== 1'b1) begin tests_failed++; $display("FAIL corrupt_done: got %0b expected 1", done_loading); end
    tests_run++; if (words_loaded !== 16'd6) begin tests_failed++; $display("FAIL corrupt_words: got %0d expected 6", words_loaded); end
  endtask

  task automatic test_timeout();
    bit fin;
    verify_en = 1'b0;
    noack_en = 1'b1;
    noack_adr = 32'h1000;
    do_reset();
    run_load(fin);
    tests_run++; if (fin !== 1'b1) begin tests_failed++; $display("FAIL tmo_finished: got %0b expected 1", fin); end
    tests_run++; if (att_len.size() != 4) begin tests_failed++; $display("FAIL tmo_attempts: got %0d expected 4", att_len.size()); end
    for (int i = 0; i < att_len.size() && i < 4; i++) begin
      tests_run++; if (att_len[i] != 8) begin tests_failed++; $display("FAIL tmo_attempt%0d_len: got %0d expected 8", i, att_len[i]); end
    end
    tests_run++; if (load_error !== 1'b1) begin tests_failed++; $display("FAIL tmo_load_error: got %0b expected 1", load_error); end
    tests_run++; if (err_count !== 8'd4) begin tests_failed++; $display("FAIL tmo_err_count: got %0d expected 4", err_count); end
    tests_run++; if (done_loading !== 1'b0) begin tests_failed++; $display("FAIL tmo_done: got %0b expected 0", done_loading); end
    tests_run++; if ({wbs_cyc, wbs_stb} !== 2'b00) begin tests_failed++; $display("FAIL tmo_cyc_stb: got %02b expected 00", {wbs_cyc, wbs_stb}); end
    tests_run++; if (flash_csb !== 1'b1) begin tests_failed++; $display("FAIL tmo_csb: got %0b expected 1", flash_csb); end
    tests_run++; if (dbg_state !== FAIL) begin tests_failed++; $display("FAIL tmo_state: got %0d expected %0d", dbg_state, FAIL); end
    noack_en = 1'b0;
  endtask

  task automatic test_wb_err();
    bit fin;
    verify_en = 1'b0;
    err_first_en = 1'b1;
    do_reset();
    run_load(fin);
    err_first_en = 1'b0;
    tests_run++; if (fin !== 1'b1) begin tests_failed++; $display("FAIL err_finished: got %0b expected 1", fin); end
    tests_run++; if (log_adr.size() != 7) begin tests_failed++; $display("FAIL err_txn_count: got %0d expected 7", log_adr.size()); end
    if (log_adr.size() >= 2) begin
      tests_run++;
      if ({log_adr[1], log_dat[1]} !== {32'h1000, 32'hA0}) begin
        tests_failed++;
        $display("FAIL err_reissue: got adr=%h dat=%h expected adr=00001000 dat=000000a0", log_adr[1], log_dat[1]);
      end
    end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL err_err_count: got %0d expected 1", err_count); end
    tests_run++; if (done_loading !== 1'b1) begin tests_failed++; $display("FAIL err_done: got %0b expected 1", done_loading); end
    tests_run++; if (words_loaded !== 16'd6) begin tests_failed++; $display("FAIL err_words: got %0d expected 6", words_loaded); end
  endtask

  task automatic test_bypass();
    bit hit;
    bit fin;
    verify_en = 1'b0;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state == WB_WRITE && wbs_stb && wbs_adr == 32'h1044) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++; if (hit !== 1'b1) begin tests_failed++; $display("FAIL byp_reach_word4: got %0b expected 1", hit); end
    tests_run++; if (words_loaded !== 16'd4) begin tests_failed++; $display("FAIL byp_words_before: got %0d expected 4", words_loaded); end
    bypass_en = 1'b1;
    @(posedge clk);
    #1;
    tests_run++; if ({wbs_cyc, wbs_stb} !== 2'b00) begin tests_failed++; $display("FAIL byp_cyc_stb: got %02b expected 00", {wbs_cyc, wbs_stb}); end
    tests_run++; if (words_loaded !== 16'd0) begin tests_failed++; $display("FAIL byp_words_cleared: got %0d expected 0", words_loaded); end
    tests_run++; if (wbs_adr !== 32'h1000) begin tests_failed++; $display("FAIL byp_adr: got %h expected 00001000", wbs_adr); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL byp_state: got %0d expected %0d", dbg_state, IDLE); end
    bypass_en = 1'b0;
    run_load(fin);
    tests_run++; if (fin !== 1'b1) begin tests_failed++; $display("FAIL byp_finished: got %0b expected 1", fin); end
    tests_run++; if (log_adr.size() != 6) begin tests_failed++; $display("FAIL byp_txn_count: got %0d expected 6", log_adr.size()); end
    if (log_adr.size() >= 1) begin
      tests_run++; if ({log_adr[0], log_dat[0]} !== {32'h1000, 32'hA0}) begin tests_failed++; $display("FAIL byp_restart: got adr=%h dat=%h expected adr=00001000 dat=000000a0", log_adr[0], log_dat[0]); end
    end
    tests_run++; if (words_loaded !== 16'd6) begin tests_failed++; $display("FAIL byp_words_after: got %0d expected 6", words_loaded); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_verify();
    test_verify_corrupt();
    test_timeout();
    test_wb_err();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
